systolic_output_deskew: RTL
===========================

Name: systolic_output_deskew

Overview:
- Receives the skewed column partial-sum outputs from the bottom edge of the systolic array.
- Column j of a given result row arrives j cycles after column 0. The block realigns all columns into one row-coherent vector and buffers rows in a FIFO.
- Rows are delivered downstream over a valid/ready handshake.
- Sits between the array's flat partial-sum output bus and the result writeback / accumulator stage.

Parameters:
- SYSTOLIC_SIZE, 8, number of array columns.
- WEIGHT_WIDTH, 8, used only to derive PARTIAL_SUM_WIDTH.
- ACTIVATION_WIDTH, 8, used only to derive PARTIAL_SUM_WIDTH.
- PARTIAL_SUM_WIDTH, WEIGHT_WIDTH+ACTIVATION_WIDTH+$clog2(SYSTOLIC_SIZE), width of one column result (19 at defaults).
- FIFO_DEPTH, 4, rows held in the output FIFO; power of two, >=2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- clear  input  1  synchronous flush: empties the deskew pipe and FIFO, clears the flag and counter.
- ps_valid  input  1  marks that column 0 of ps_in_flat carries a valid row result this cycle.
- ps_in_flat  input  SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH  skewed array outputs; column j at [j*PSW +: PSW].
- out_valid  output  1  head FIFO row is available.
- out_ready  input  1  downstream accepts the row.
- out_data_flat  output  SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH  aligned row; column j at [j*PSW +: PSW].
- fifo_count  output  $clog2(FIFO_DEPTH)+1  rows currently held.
- overflow  output  1  sticky: a row was dropped because the FIFO was full.
- rows_out  output  16  count of rows accepted downstream; wraps at 2^16.

Behaviour:
- Deskew:
  - Column j passes through SYSTOLIC_SIZE-1-j registers; column SYSTOLIC_SIZE-1 is unregistered.
  - ps_valid passes through a SYSTOLIC_SIZE-1 stage valid shift register.
  - The aligned row is formed from the pipe tails plus the live last column. Its valid is the tail of the valid shift.
  - The data pipes always shift, no enable; only valid gates FIFO writes.
- FIFO write:
  - Aligned valid with FIFO not full: row written at that clock edge.
  - Aligned valid with FIFO full and no pop that cycle: row dropped, overflow set to 1 (sticky until clear or reset).
  - Full with simultaneous pop (out_valid&&out_ready): write succeeds, count unchanged, no overflow.
- FIFO read:
  - out_valid = (fifo_count != 0).
  - out_data_flat = head entry, stable while out_valid && !out_ready.
  - A pop occurs on out_valid&&out_ready at the clock edge; rows_out increments by 1 on each pop.
  - Simultaneous push and pop when empty: the push is not visible until the next cycle (no bypass).
- Latency: ps_valid at cycle T gives out_valid at cycle T+SYSTOLIC_SIZE when the FIFO is empty (SYSTOLIC_SIZE-1 deskew + 1 FIFO write). Throughput is one row per cycle with out_ready held high.
- Pointers: read/write pointers of $clog2(FIFO_DEPTH) bits wrap modulo FIFO_DEPTH; full/empty come from fifo_count.
- clear:
  - Zeroes the valid shift register, pointers, fifo_count, overflow and rows_out at the next edge.
  - Data pipes need not be cleared.
  - clear has priority over push/pop in the same cycle.
  - ps_valid in the same cycle as clear is discarded.
- Reset, asynchronous:
  - out_valid=0, fifo_count=0, overflow=0, rows_out=0.
  - valid shift register=0, pointers=0.
  - out_data_flat=0, since FIFO storage and data pipes are reset.
  - Reset mid-stream discards all in-flight rows; no spurious out_valid after release.
- Arithmetic: pure data movement; no widening, truncation or sign handling.

Decomposition:
- Shared package holds SYSTOLIC_SIZE, WEIGHT_WIDTH, ACTIVATION_WIDTH and the derived PARTIAL_SUM_WIDTH localparam, so the array, feeder and this block agree on widths.
- One natural sub-module, deskew_delay_line: parameterised width and depth shift register with async reset. It is instantiated per column (depth SYSTOLIC_SIZE-1-j) and once for the valid bit.
- The FIFO stays inline.

Test Plan:
- Single row: after reset, ps_valid at T=10; column j driven with value 100+j at cycle 10+j, out_ready=1 -> out_valid only at cycle 18; out_data column j = 100+j; rows_out=1.
- Streaming: 20 back-to-back rows (row r column j = r*16+j) with out_ready=1 -> 20 consecutive out_valid cycles; data in order; fifo_count<=1; overflow=0.
- Backpressure/overflow: out_ready=0, 6 rows at FIFO_DEPTH=4 -> fifo_count=4; rows 5 and 6 dropped; overflow=1; after out_ready=1 exactly rows 1-4 appear; rows_out=4.
- Full with simultaneous pop: FIFO full, out_ready=1 in the same cycle an aligned row arrives -> row accepted, fifo_count stays 4, overflow stays 0.
- clear/reset mid-operation: rows in the deskew pipe and 2 in the FIFO; assert clear (then separately rst_n=0 asynchronously mid-cycle) -> fifo_count=0, out_valid=0 immediately after; no rows emerge over the next 2*SYSTOLIC_SIZE cycles; overflow=0; rows_out=0.
- Counter wrap: force 65536 pops -> rows_out returns to 0.

Source files
------------

// File: rtl/systolic_output_deskew_pkg.sv
// Shared sizing for the systolic array, its feeders and the output deskew.
// Everything that moves partial sums agrees on column count and result width
// through these constants.
//   SYSTOLIC_SIZE     : number of array columns
//   WEIGHT_WIDTH      : weight operand width
//   ACTIVATION_WIDTH  : activation operand width
//   PARTIAL_SUM_WIDTH : width of one accumulated column result
package systolic_output_deskew_pkg;

    localparam int SYSTOLIC_SIZE     = 8;
    localparam int WEIGHT_WIDTH      = 8;
    localparam int ACTIVATION_WIDTH  = 8;
    localparam int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE);

    // Pointer width for a power-of-two buffer; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/systolic_output_deskew_delay_line.sv
// Fixed-depth shift register used to delay one column (or the valid bit)
// of the skewed array output so all columns line up.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all stages)
//   clear      : synchronous zeroing of every stage (tie low for data pipes)
//   din        : value entering the line this cycle
//   dout       : value that entered DEPTH cycles ago (din itself when DEPTH=0)
module systolic_output_deskew_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            // The last array column arrives already aligned: pure feed-through.
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, clear};
            assign dout        = din;
        end else begin : g_regs
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else if (clear) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_output_deskew.sv
// Realigns the skewed column outputs from the bottom edge of the systolic
// array into whole rows and buffers them for the writeback stage.
// Column j of a row arrives j cycles after column 0, so column j is delayed
// by SYSTOLIC_SIZE-1-j cycles; the valid bit travels the full SYSTOLIC_SIZE-1.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear         : synchronous flush of deskew valids, FIFO, overflow, rows_out
//   ps_valid      : column 0 of ps_in_flat starts a valid row this cycle
//   ps_in_flat    : skewed column results, column j at [j*PSW +: PSW]
//   out_valid     : head row of the FIFO is available
//   out_ready     : downstream accepts the head row
//   out_data_flat : head row, column j at [j*PSW +: PSW]
//   fifo_count    : rows currently buffered
//   overflow      : sticky, a row was dropped because the FIFO was full
//   rows_out      : rows accepted downstream, wraps at 2^16
module systolic_output_deskew #(
    parameter int SYSTOLIC_SIZE     = systolic_output_deskew_pkg::SYSTOLIC_SIZE,
    parameter int WEIGHT_WIDTH      = systolic_output_deskew_pkg::WEIGHT_WIDTH,
    parameter int ACTIVATION_WIDTH  = systolic_output_deskew_pkg::ACTIVATION_WIDTH,
    parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       clear,
    input  logic                                       ps_valid,
    input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] ps_in_flat,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] out_data_flat,
    output logic [$clog2(FIFO_DEPTH):0]                fifo_count,
    output logic                                       overflow,
    output logic [15:0]                                rows_out
);

    import systolic_output_deskew_pkg::*;

    localparam int PSW   = PARTIAL_SUM_WIDTH;
    localparam int ROW_W = SYSTOLIC_SIZE * PSW;
    localparam int PTR_W = ptr_width(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ROW_W-1:0] aligned_row_p0;
    logic             aligned_vld_p0;

    // Deskew: per-column delay lines; data never stalls, only valid gates writes.
    generate
        for (genvar j = 0; j < SYSTOLIC_SIZE; j++) begin : g_col
            systolic_output_deskew_delay_line #(
                .WIDTH (PSW),
                .DEPTH (SYSTOLIC_SIZE - 1 - j)
            ) u_col_delay (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (1'b0),
                .din   (ps_in_flat[j*PSW +: PSW]),
                .dout  (aligned_row_p0[j*PSW +: PSW])
            );
        end
    endgenerate

    systolic_output_deskew_delay_line #(
        .WIDTH (1),
        .DEPTH (SYSTOLIC_SIZE - 1)
    ) u_vld_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .din   (ps_valid),
        .dout  (aligned_vld_p0)
    );

    // FIFO: aligned row is written at the edge ending the cycle it is valid.
    logic [ROW_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic [15:0]      rows_q;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = (count_q != '0) && out_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign push      = aligned_vld_p0 && (!fifo_full || pop);
    assign drop      = aligned_vld_p0 && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rows_q     <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rows_q     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                rows_q <= rows_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (push && !clear) begin
            fifo_mem[wr_ptr] <= aligned_row_p0;
        end
    end

    // Output: head entry read straight from storage, no write-through bypass.
    assign out_valid     = (count_q != '0);
    assign out_data_flat = fifo_mem[rd_ptr];
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign rows_out      = rows_q;

endmodule
